bp_me_wormhole_flit_serializer: RTL and testbench

BP_ME_WORMHOLE_FLIT_SERIALIZER -- requirements
Module: bp_me_wormhole_flit_serializer

---
 rtl/bp_me_wormhole_flit_serializer.sv | 91 +++++++++
 tb/tb_bp_me_wormhole_flit_serializer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/bp_me_wormhole_flit_serializer.sv
// Splits one coherence message into num_flits_p wormhole flits, header flit first.
// state | meaning
// IDLE  | ready_o high, link idle, waiting for a packet
// SEND  | driving flit[cnt] on link_o until the last flit transfers
module bp_me_wormhole_flit_serializer #(
   parameter int flit_width_p    = 64,
   parameter int payload_width_p = 128,
   parameter int x_cord_width_p  = 2,
   parameter int y_cord_width_p  = 1,
   parameter int num_flits_p     = 3
) (
   input  logic                         clk_i,
   input  logic                         reset_i,
   input  logic                         v_i,
   output logic                         ready_o,
   input  logic [payload_width_p-1:0]   payload_i,
   input  logic [x_cord_width_p-1:0]    dest_x_i,
   input  logic [y_cord_width_p-1:0]    dest_y_i,
   input  logic [flit_width_p+1:0]      link_i,
   output logic [flit_width_p+1:0]      link_o
);

   localparam int len_width_lp    = (num_flits_p > 1) ? $clog2(num_flits_p) : 1;
   localparam int packet_width_lp = payload_width_p + len_width_lp + y_cord_width_p + x_cord_width_p;
   localparam int padded_width_lp = num_flits_p * flit_width_p;
   localparam logic [len_width_lp-1:0] last_cnt_lp = len_width_lp'(num_flits_p - 1);

   if (packet_width_lp > padded_width_lp) begin : g_width_check
      $error("packet does not fit in num_flits_p flits");
   end
   if (num_flits_p < 1 || num_flits_p > 16) begin : g_flits_check
      $error("num_flits_p must be within 1..16");
   end

   typedef enum logic {e_idle, e_send} state_e;

   state_e                      state_r;
   logic [len_width_lp-1:0]     cnt_r;
   logic [padded_width_lp-1:0]  packet_r;
   logic [padded_width_lp-1:0]  packet_n;
   logic [flit_width_p-1:0]     flit;
   logic                        ready_and;
   logic                        unused_link;

   assign ready_and   = link_i[flit_width_p];
   assign unused_link = ^{link_i[flit_width_p+1], link_i[flit_width_p-1:0]};

   // len always advertises the full flit count minus the header flit
   assign packet_n = padded_width_lp'({payload_i, last_cnt_lp, dest_y_i, dest_x_i});

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_r  <= e_idle;
         cnt_r    <= '0;
         packet_r <= '0;
      end else begin
         case (state_r)
            e_idle: begin
               if (v_i) begin
                  packet_r <= packet_n;
                  cnt_r    <= '0;
                  state_r  <= e_send;
               end
            end
            e_send: begin
               if (ready_and) begin
                  if (cnt_r == last_cnt_lp) begin
                     state_r <= e_idle;
                  end else begin
                     cnt_r <= cnt_r + 1'b1;
                  end
               end
            end
            default: state_r <= e_idle;
         endcase
      end
   end

   always_comb begin
      flit = '0;
      for (int i = 0; i < num_flits_p; i++) begin
         if (cnt_r == len_width_lp'(i)) begin
            flit = packet_r[i*flit_width_p +: flit_width_p];
         end
      end
   end

   assign ready_o = (state_r == e_idle);
   assign link_o  = (state_r == e_send) ? {1'b1, 1'b0, flit} : '0;

endmodule

// File: tb/tb_bp_me_wormhole_flit_serializer.sv
// Directed bench for the flit serializer: default 3-flit build and a 1-flit build.
module tb_bp_me_wormhole_flit_serializer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset_i;
   logic          v_a, ready_a;
   logic [127:0]  pl_a;
   logic [1:0]    x_a;
   logic [0:0]    y_a;
   logic [65:0]   li_a, lo_a;
   logic          v_b, ready_b;
   logic [59:0]   pl_b;
   logic [1:0]    x_b;
   logic [0:0]    y_b;
   logic [65:0]   li_b, lo_b;

   bp_me_wormhole_flit_serializer dut_a (
      .clk_i(clk), .reset_i(reset_i), .v_i(v_a), .ready_o(ready_a),
      .payload_i(pl_a), .dest_x_i(x_a), .dest_y_i(y_a),
      .link_i(li_a), .link_o(lo_a)
   );

   bp_me_wormhole_flit_serializer #(
      .flit_width_p(64), .payload_width_p(60), .num_flits_p(1)
   ) dut_b (
      .clk_i(clk), .reset_i(reset_i), .v_i(v_b), .ready_o(ready_b),
      .payload_i(pl_b), .dest_x_i(x_b), .dest_y_i(y_b),
      .link_i(li_b), .link_o(lo_b)
   );

   int tests = 0;
   int fails = 0;
   int cyc   = 0;
   int xfer_a = 0, xfer_b = 0;
   logic [63:0] qa[$], qb[$];
   int acc_a[$], acc_b[$];
   logic [191:0] pm;

   // packet = {payload, len, y, x} with x 2 bits, y 1 bit, len lw bits
   function automatic logic [191:0] build(input logic [127:0] pl, input logic [1:0] x,
                                          input logic y, input int lw, input int n);
      return (192'(pl) << (3 + lw)) | (192'(n - 1) << 3) | (192'(y) << 2) | 192'(x);
   endfunction

   // Behavioural model: a queue of flits still owed per DUT
   always @(posedge clk) begin
      cyc++;
      if (reset_i) begin
         qa.delete();
         qb.delete();
      end else begin
         if (qa.size() == 0) begin
            if (v_a) begin
               pm = build(pl_a, x_a, y_a[0], 2, 3);
               for (int k = 0; k < 3; k++) qa.push_back(pm[k*64 +: 64]);
               acc_a.push_back(cyc);
            end
         end else if (li_a[64]) begin
            void'(qa.pop_front());
            xfer_a++;
         end
         if (qb.size() == 0) begin
            if (v_b) begin
               pm = build(128'(pl_b), x_b, y_b[0], 1, 1);
               qb.push_back(pm[63:0]);
               acc_b.push_back(cyc);
            end
         end else if (li_b[64]) begin
            void'(qb.pop_front());
            xfer_b++;
         end
      end
   end

   task automatic compare();
      logic [66:0] ea, eb;
      ea = (qa.size() != 0 && !reset_i) ? {1'b0, 2'b10, qa[0]} : {1'b1, 66'd0};
      eb = (qb.size() != 0 && !reset_i) ? {1'b0, 2'b10, qb[0]} : {1'b1, 66'd0};
      tests++;
      if ({ready_a, lo_a} !== ea) begin
         fails++;
         $display("FAIL model_a cyc=%0d actual=%h required=%h", cyc, {ready_a, lo_a}, ea);
      end
      tests++;
      if ({ready_b, lo_b} !== eb) begin
         fails++;
         $display("FAIL model_b cyc=%0d actual=%h required=%h", cyc, {ready_b, lo_b}, eb);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      compare();
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic send(input bit d, input logic [127:0] pl, input logic [1:0] x, input logic y);
      int guard;
      if (!d) begin
         v_a = 1'b1; pl_a = pl; x_a = x; y_a = y;
      end else begin
         v_b = 1'b1; pl_b = pl[59:0]; x_b = x; y_b = y;
      end
      guard = 0;
      while (((d ? ready_b : ready_a) !== 1'b1) && guard < 50) begin
         tick();
         guard++;
      end
      chk("send_accept_timeout", 64'(guard >= 50), 64'd0);
      tick();
      if (!d) v_a = 1'b0;
      else    v_b = 1'b0;
   endtask

   logic [7:0] pat;
   int x0;

   initial begin
      reset_i = 1'b1;
      v_a = 1'b0; pl_a = '0; x_a = '0; y_a = '0; li_a = '0;
      v_b = 1'b0; pl_b = '0; x_b = '0; y_b = '0; li_b = '0;
      tick();
      chk("reset_ready_a", 64'(ready_a), 64'd1);
      chk("reset_link_a", lo_a[63:0], 64'd0);
      chk("reset_link_a_v", 64'(lo_a[65:64]), 64'd0);
      reset_i = 1'b0;

      // Defaults with ready held: header fields, payload at bit 5
      li_a = {1'b0, 1'b1, 64'd0};
      send(1'b0, {64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555}, 2'd2, 1'b1);
      chk("first_accept_cycle", 64'(acc_a[0]), 64'd2);
      chk("flit0_v", 64'(lo_a[65]), 64'd1);
      chk("flit0_data", lo_a[63:0], 64'hAAAA_AAAA_AAAA_AAB6);
      chk("flit0_ready", 64'(ready_a), 64'd0);
      tick();
      chk("flit1_data", lo_a[63:0], 64'h5555_5555_5555_554A);
      tick();
      chk("flit2_data", lo_a[63:0], 64'h0000_0000_0000_0015);
      tick();
      chk("after_last_v", 64'(lo_a[65]), 64'd0);
      chk("after_last_ready", 64'(ready_a), 64'd1);

      // Junk on link_i.v/data while idle must not start anything
      li_a = {1'b1, 1'b1, 64'hDEAD_BEEF_0BAD_F00D};
      li_b = {1'b1, 1'b1, 64'hFFFF_0000_FFFF_0000};
      for (int i = 0; i < 3; i++) tick();
      chk("junk_idle_a", {62'd0, lo_a[65:64]}, 64'd0);
      chk("junk_idle_b", {62'd0, lo_b[65:64]}, 64'd0);

      // Back-to-back packets: period num_flits_p+1
      li_a = {1'b0, 1'b1, 64'd0};
      send(1'b0, 128'h1111_2222_3333_4444_5555_6666_7777_8888, 2'd1, 1'b0);
      send(1'b0, 128'h9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF_0000, 2'd3, 1'b1);
      chk("b2b_period_a", 64'(acc_a[2] - acc_a[1]), 64'd4);
      for (int i = 0; i < 4; i++) tick();

      // Stalls: ready_and pattern 1,0,0,1,0,1,0,0
      li_a = {1'b0, 1'b0, 64'd0};
      x0 = xfer_a;
      send(1'b0, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 2'd0, 1'b1);
      pat = 8'b0010_1001;
      for (int i = 0; i < 8; i++) begin
         li_a[64] = pat[i];
         tick();
      end
      chk("stall_transfers", 64'(xfer_a - x0), 64'd3);
      chk("stall_done_ready", 64'(ready_a), 64'd1);

      // Reset mid-packet aborts immediately
      li_a = {1'b0, 1'b1, 64'd0};
      send(1'b0, 128'hCAFE_0000_0000_0000_0000_0000_0000_BEEF, 2'd1, 1'b1);
      tick();
      reset_i = 1'b1;
      #1;
      chk("async_reset_v", 64'(lo_a[65]), 64'd0);
      chk("async_reset_data", lo_a[63:0], 64'd0);
      chk("async_reset_ready", 64'(ready_a), 64'd1);
      tick();
      reset_i = 1'b0;
      send(1'b0, 128'd0, 2'd3, 1'b0);
      chk("post_reset_flit0", lo_a[63:0], 64'h13);
      chk("post_reset_v", 64'(lo_a[65]), 64'd1);
      for (int i = 0; i < 4; i++) tick();

      // Single-flit build
      li_b = {1'b0, 1'b1, 64'd0};
      send(1'b1, 128'h0123_4567_89AB_CDEF, 2'd1, 1'b0);
      chk("n1_flit", lo_b[63:0], 64'h1234_5678_9ABC_DEF1);
      chk("n1_ready", 64'(ready_b), 64'd0);
      send(1'b1, 128'h0FED_CBA9_8765_4321, 2'd2, 1'b1);
      chk("n1_flit2", lo_b[63:0], 64'hFEDC_BA98_7654_3216);
      chk("n1_period", 64'(acc_b[acc_b.size()-1] - acc_b[acc_b.size()-2]), 64'd2);
      for (int i = 0; i < 3; i++) tick();
      chk("n1_idle_ready", 64'(ready_b), 64'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
